// File: rtl/alu_issue_arbiter_pkg.sv
// Shared ALU types for the issue arbiter: opcodes, operand type and the muxed request bundle.
package alu_issue_arbiter_pkg;

    typedef logic [31:0] register_t;

    typedef enum logic [2:0] {
        M_ADD = 3'd0,
        M_AND = 3'd1,
        M_OR  = 3'd2,
        M_XOR = 3'd3,
        M_SLL = 3'd4,
        M_SRL = 3'd5
    } instruction_t;

    typedef struct packed {
        instruction_t instr;
        register_t    op1;
        register_t    op2;
    } alu_req_t;

    localparam int unsigned ALU_ARB_MAX_REQ = 8;

endpackage

// File: rtl/alu_issue_arbiter_rr.sv
// Combinational round-robin pick: first eligible requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         eligible,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant
);
    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    always_comb begin
        logic [PTR_W:0] idx;
        logic           found;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            // ptr + k < 2*NUM_REQ, so one subtraction is enough to wrap
            idx = {1'b0, ptr} + (PTR_W + 1)'(k);
            if (idx >= (PTR_W + 1)'(NUM_REQ)) begin
                idx = idx - (PTR_W + 1)'(NUM_REQ);
            end
            if (!found && eligible[idx[PTR_W-1:0]]) begin
                grant[idx[PTR_W-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter sharing one ALU between NUM_REQ requesters.
// Define ALU_ARB_PERF_EN to build the per-requester grant and stall counters.
module alu_issue_arbiter
    import alu_issue_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ALU_LAT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  instruction_t [NUM_REQ-1:0] req_instr,
    input  register_t [NUM_REQ-1:0]   req_op1,
    input  register_t [NUM_REQ-1:0]   req_op2,
    input  logic [NUM_REQ-1:0]        req_mask,
    input  logic                      kill,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output register_t                 rsp_result,
    output logic                      alu_enable,
    output instruction_t              alu_instr,
    output register_t                 alu_op1,
    output register_t                 alu_op2,
    input  register_t                 alu_result,
    output logic [NUM_REQ-1:0][31:0]  perf_grants,
    output logic [31:0]               perf_stalls
);
    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] eligible, arb_elig, grant;
    logic [PTR_W-1:0]   grant_id;
    logic               transfer;
    logic               rsp_live;
    alu_req_t           issue_req;

    logic               pipe_vld_q [ALU_LAT];
    logic               pipe_vld_d [ALU_LAT];
    logic [PTR_W-1:0]   pipe_id_q  [ALU_LAT];
    logic [PTR_W-1:0]   pipe_id_d  [ALU_LAT];

    // Stall accounting uses eligible; grants are additionally blocked during kill.
    always_comb begin
        eligible = req_valid & ~req_mask & {NUM_REQ{~rst}};
        arb_elig = eligible & {NUM_REQ{~kill}};
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .eligible (arb_elig),
        .ptr      (ptr_q),
        .grant    (grant)
    );

    always_comb begin
        req_ready = grant;
        transfer  = |(req_valid & grant);
        grant_id  = '0;
        issue_req = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_id        = PTR_W'(i);
                issue_req.instr = req_instr[i];
                issue_req.op1   = req_op1[i];
                issue_req.op2   = req_op2[i];
            end
        end
        alu_enable = transfer;
        alu_instr  = issue_req.instr;
        alu_op1    = issue_req.op1;
        alu_op2    = issue_req.op2;

        ptr_d = ptr_q;
        if (transfer) begin
            ptr_d = (grant_id == PTR_W'(NUM_REQ - 1)) ? '0 : grant_id + PTR_W'(1);
        end

        pipe_vld_d[0] = transfer & ~kill;
        pipe_id_d[0]  = grant_id;
        for (int unsigned k = 1; k < ALU_LAT; k++) begin
            pipe_vld_d[k] = pipe_vld_q[k-1] & ~kill;
            pipe_id_d[k]  = pipe_id_q[k-1];
        end

        rsp_live = pipe_vld_q[ALU_LAT-1] & ~rst;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = rsp_live && (pipe_id_q[ALU_LAT-1] == PTR_W'(i));
        end
        rsp_result = rsp_live ? alu_result : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            for (int unsigned k = 0; k < ALU_LAT; k++) begin
                pipe_vld_q[k] <= 1'b0;
                pipe_id_q[k]  <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            for (int unsigned k = 0; k < ALU_LAT; k++) begin
                pipe_vld_q[k] <= pipe_vld_d[k];
                pipe_id_q[k]  <= pipe_id_d[k];
            end
        end
    end

`ifdef ALU_ARB_PERF_EN
    logic [31:0] perf_grants_q [NUM_REQ];
    logic [31:0] perf_grants_d [NUM_REQ];
    logic [31:0] perf_stalls_q, perf_stalls_d;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            perf_grants_d[i] = perf_grants_q[i] + 32'(transfer & grant[i]);
            perf_grants[i]   = perf_grants_q[i];
        end
        perf_stalls_d = perf_stalls_q + 32'(|(eligible & ~grant));
        perf_stalls   = perf_stalls_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                perf_grants_q[i] <= '0;
            end
            perf_stalls_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                perf_grants_q[i] <= perf_grants_d[i];
            end
            perf_stalls_q <= perf_stalls_d;
        end
    end
`else
    always_comb begin
        perf_grants = '0;
        perf_stalls = '0;
    end
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Self-checking bench for alu_issue_arbiter: behavioural arbitration model, ALU oracle, response scoreboard.
module tb_alu_issue_arbiter;
    import alu_issue_arbiter_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int ALU_LAT = 2;
`ifdef ALU_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic                       clk;
    logic                       rst;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    instruction_t [NUM_REQ-1:0] req_instr;
    register_t [NUM_REQ-1:0]    req_op1;
    register_t [NUM_REQ-1:0]    req_op2;
    logic [NUM_REQ-1:0]         req_mask;
    logic                       kill;
    logic [NUM_REQ-1:0]         rsp_valid;
    register_t                  rsp_result;
    logic                       alu_enable;
    instruction_t               alu_instr;
    register_t                  alu_op1;
    register_t                  alu_op2;
    register_t                  alu_result;
    logic [NUM_REQ-1:0][31:0]   perf_grants;
    logic [31:0]                perf_stalls;

    alu_issue_arbiter #(.NUM_REQ(NUM_REQ), .ALU_LAT(ALU_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_instr   (req_instr),
        .req_op1     (req_op1),
        .req_op2     (req_op2),
        .req_mask    (req_mask),
        .kill        (kill),
        .rsp_valid   (rsp_valid),
        .rsp_result  (rsp_result),
        .alu_enable  (alu_enable),
        .alu_instr   (alu_instr),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_result  (alu_result),
        .perf_grants (perf_grants),
        .perf_stalls (perf_stalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus for the current cycle
    logic               v_rst, v_kill;
    logic [NUM_REQ-1:0] v_valid, v_mask;
    logic [2:0]         v_instr [NUM_REQ];
    logic [31:0]        v_op1 [NUM_REQ];
    logic [31:0]        v_op2 [NUM_REQ];

    // Reference model state
    typedef struct {
        int          due;
        int          id;
        logic [31:0] res;
    } rsp_t;
    rsp_t        m_q[$];
    int          m_ptr = 0;
    int          m_cyc = 0;
    int          m_g;
    logic [31:0] m_pg [NUM_REQ];
    logic [31:0] m_ps = '0;
    logic [31:0] alu_stage [ALU_LAT];

    // Observed and expected per-cycle vectors
    logic [107:0] obs_io, exp_io;
    logic [159:0] obs_perf, exp_perf;
    logic [3:0]   obs_ready, obs_rsp_v;
    logic [31:0]  obs_rsp_r;
    logic         s_en;
    logic [2:0]   s_instr;
    logic [31:0]  s_op1, s_op2;

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            M_ADD:   return a + b;
            M_AND:   return a & b;
            M_OR:    return a | b;
            M_XOR:   return a ^ b;
            M_SLL:   return a << b[4:0];
            M_SRL:   return a >> b[4:0];
            default: return 32'h0;
        endcase
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < NUM_REQ; i++) begin
            v_instr[i] = 3'($urandom_range(0, 5));
            v_op1[i]   = $urandom;
            v_op2[i]   = $urandom;
        end
    endtask

    // One clock cycle: drive, sample mid-cycle, predict, then advance model and ALU across the edge.
    task automatic cycle();
        int          n_elig;
        logic [3:0]  e_ready, e_rv;
        logic        e_en;
        logic [2:0]  e_instr;
        logic [31:0] e_op1, e_op2, e_rr;
        rst       = v_rst;
        kill      = v_kill;
        req_valid = v_valid;
        req_mask  = v_mask;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_instr[i] = instruction_t'(v_instr[i]);
            req_op1[i]   = v_op1[i];
            req_op2[i]   = v_op2[i];
        end
        alu_result = alu_stage[ALU_LAT-1];
        #4;
        s_en = alu_enable; s_instr = alu_instr; s_op1 = alu_op1; s_op2 = alu_op2;
        obs_ready = req_ready; obs_rsp_v = rsp_valid; obs_rsp_r = rsp_result;
        obs_io   = {obs_ready, s_en, s_instr, s_op1, s_op2, obs_rsp_v, obs_rsp_r};
        obs_perf = {perf_grants, perf_stalls};

        m_g = -1;
        n_elig = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NUM_REQ;
            if (!v_rst && v_valid[idx] && !v_mask[idx]) begin
                n_elig++;
                if (m_g < 0 && !v_kill) m_g = idx;
            end
        end
        e_ready = '0; e_en = 1'b0; e_instr = '0; e_op1 = '0; e_op2 = '0;
        if (m_g >= 0) begin
            e_ready = 4'b0001 << m_g;
            e_en    = 1'b1;
            e_instr = v_instr[m_g];
            e_op1   = v_op1[m_g];
            e_op2   = v_op2[m_g];
        end
        e_rv = '0; e_rr = '0;
        if (!v_rst && m_q.size() > 0 && m_q[0].due == m_cyc) begin
            e_rv = 4'b0001 << m_q[0].id;
            e_rr = m_q[0].res;
        end
        exp_io = {e_ready, e_en, e_instr, e_op1, e_op2, e_rv, e_rr};
        exp_perf = '0;
        if (PERF) begin
            for (int i = 0; i < NUM_REQ; i++) exp_perf[32 + 32*i +: 32] = m_pg[i];
            exp_perf[31:0] = m_ps;
        end

        @(posedge clk);
        #1;
        for (int k = ALU_LAT - 1; k > 0; k--) alu_stage[k] = alu_stage[k-1];
        alu_stage[0] = s_en ? alu_ref(s_instr, s_op1, s_op2) : 32'hDEAD_BEEF;

        if (v_rst) begin
            m_ptr = 0;
            m_q.delete();
            for (int i = 0; i < NUM_REQ; i++) m_pg[i] = '0;
            m_ps = '0;
        end else begin
            if (m_q.size() > 0 && m_q[0].due == m_cyc) void'(m_q.pop_front());
            if (v_kill) m_q.delete();
            if (n_elig > ((m_g >= 0) ? 1 : 0)) m_ps++;
            if (m_g >= 0) begin
                m_q.push_back('{due: m_cyc + ALU_LAT, id: m_g, res: alu_ref(v_instr[m_g], v_op1[m_g], v_op2[m_g])});
                m_pg[m_g]++;
                m_ptr = (m_g + 1) % NUM_REQ;
            end
        end
        m_cyc++;
    endtask

    task automatic idle(input int n);
        v_valid = '0; v_kill = 1'b0; v_rst = 1'b0;
        for (int k = 0; k < n; k++) begin
            cycle();
            vectors++;
            if (obs_io !== exp_io) begin
                miscompares++;
                $display("FAIL idle_io cyc=%0d got=%h exp=%h", m_cyc, obs_io, exp_io);
            end
        end
    endtask

    task automatic test_reset();
        v_rst = 1'b1; v_kill = 1'b0; v_mask = '0; v_valid = '1;
        rand_ops();
        cycle();
        cycle();
        vectors++;
        if (obs_io !== '0) begin
            miscompares++;
            $display("FAIL reset_io got=%h exp=0", obs_io);
        end
        vectors++;
        if (obs_perf !== '0) begin
            miscompares++;
            $display("FAIL reset_perf got=%h exp=0", obs_perf);
        end
        v_rst = 1'b0;
    endtask

    task automatic test_round_robin();
        v_valid = '1; v_mask = '0;
        for (int k = 0; k < 12; k++) begin
            rand_ops();
            cycle();
            vectors++;
            if (obs_io !== exp_io) begin
                miscompares++;
                $display("FAIL rr_io cyc=%0d got=%h exp=%h", m_cyc, obs_io, exp_io);
            end
            vectors++;
            if (obs_ready !== (4'b0001 << (k % 4)) || s_en !== 1'b1) begin
                miscompares++;
                $display("FAIL rr_grant k=%0d got=%b en=%b exp=%b", k, obs_ready, s_en, 4'b0001 << (k % 4));
            end
            if (k >= 2) begin
                vectors++;
                if (obs_rsp_v !== (4'b0001 << ((k - 2) % 4))) begin
                    miscompares++;
                    $display("FAIL rr_rsp k=%0d got=%b exp=%b", k, obs_rsp_v, 4'b0001 << ((k - 2) % 4));
                end
            end
        end
    endtask

    task automatic test_single();
        idle(3);
        v_mask = '0;
        v_instr[1] = 3'(M_ADD); v_op1[1] = 32'd5; v_op2[1] = 32'd7;
        for (int k = 0; k < 4; k++) begin
            v_valid = (k == 0) ? 4'b0010 : 4'b0000;
            cycle();
            vectors++;
            if (obs_io !== exp_io) begin
                miscompares++;
                $display("FAIL single_io k=%0d got=%h exp=%h", k, obs_io, exp_io);
            end
            if (k == 0) begin
                vectors++;
                if (obs_ready !== 4'b0010) begin
                    miscompares++;
                    $display("FAIL single_ready got=%b exp=0010", obs_ready);
                end
            end
            if (k == 2) begin
                vectors++;
                if (obs_rsp_v !== 4'b0010 || obs_rsp_r !== 32'd12) begin
                    miscompares++;
                    $display("FAIL single_rsp got=%b/%0d exp=0010/12", obs_rsp_v, obs_rsp_r);
                end
            end
        end
    endtask

    task automatic test_mask();
        logic [3:0] prev;
        v_valid = '1; v_mask = 4'b0101;
        prev = '0;
        for (int k = 0; k < 8; k++) begin
            rand_ops();
            cycle();
            vectors++;
            if (obs_io !== exp_io) begin
                miscompares++;
                $display("FAIL mask_io k=%0d got=%h exp=%h", k, obs_io, exp_io);
            end
            vectors++;
            if (!(obs_ready === 4'b0010 || obs_ready === 4'b1000) || obs_ready === prev) begin
                miscompares++;
                $display("FAIL mask_grant k=%0d got=%b prev=%b exp=0010/1000 alternating", k, obs_ready, prev);
            end
            prev = obs_ready;
        end
        v_mask = '0;
    endtask

    task automatic test_kill();
        int nrsp;
        idle(3);
        nrsp = 0;
        for (int k = 0; k < 6; k++) begin
            rand_ops();
            v_valid = (k < 3) ? 4'b0001 : 4'b0000;
            v_kill  = (k == ALU_LAT);
            cycle();
            vectors++;
            if (obs_io !== exp_io) begin
                miscompares++;
                $display("FAIL kill_io k=%0d got=%h exp=%h", k, obs_io, exp_io);
            end
            if (k == ALU_LAT) begin
                vectors++;
                if (obs_ready !== 4'b0000 || s_en !== 1'b0) begin
                    miscompares++;
                    $display("FAIL kill_grant got=%b en=%b exp=0000/0", obs_ready, s_en);
                end
            end
            if (obs_rsp_v !== 4'b0000) nrsp++;
        end
        v_kill = 1'b0;
        vectors++;
        if (nrsp !== 1) begin
            miscompares++;
            $display("FAIL kill_rsp_count got=%0d exp=1", nrsp);
        end
    endtask

    task automatic test_rst_mid();
        idle(3);
        for (int k = 0; k < 5; k++) begin
            rand_ops();
            v_valid = (k == 0) ? 4'b0100 : (k <= 2) ? 4'b1111 : 4'b0000;
            v_rst   = (k == 1);
            cycle();
            vectors++;
            if (obs_io !== exp_io) begin
                miscompares++;
                $display("FAIL rstmid_io k=%0d got=%h exp=%h", k, obs_io, exp_io);
            end
            if (k >= 1 && k <= 3) begin
                vectors++;
                if (obs_rsp_v !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL rstmid_rsp k=%0d got=%b exp=0000", k, obs_rsp_v);
                end
            end
            if (k == 2) begin
                vectors++;
                if (obs_ready !== 4'b0001) begin
                    miscompares++;
                    $display("FAIL rstmid_first_grant got=%b exp=0001", obs_ready);
                end
            end
        end
        v_rst = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            rand_ops();
            v_valid = 4'($urandom);
            v_mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            v_kill  = ($urandom_range(0, 15) == 0);
            v_rst   = ($urandom_range(0, 63) == 0);
            cycle();
            vectors++;
            if (obs_io !== exp_io) begin
                miscompares++;
                $display("FAIL random_io k=%0d got=%h exp=%h", k, obs_io, exp_io);
            end
            vectors++;
            if (obs_perf !== exp_perf) begin
                miscompares++;
                $display("FAIL random_perf k=%0d got=%h exp=%h", k, obs_perf, exp_perf);
            end
        end
        v_rst = 1'b0; v_kill = 1'b0; v_mask = '0;
    endtask

    task automatic test_perf();
        logic [159:0] want;
        v_rst = 1'b1; v_valid = '1; v_mask = '0; v_kill = 1'b0;
        cycle();
        v_rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rand_ops();
            cycle();
            vectors++;
            if (obs_perf !== exp_perf) begin
                miscompares++;
                $display("FAIL perf_track k=%0d got=%h exp=%h", k, obs_perf, exp_perf);
            end
        end
        idle(1);
        want = '0;
        if (PERF) begin
            for (int i = 0; i < NUM_REQ; i++) want[32 + 32*i +: 32] = 32'd2;
            want[31:0] = 32'd8;
        end
        vectors++;
        if (obs_perf !== want) begin
            miscompares++;
            $display("FAIL perf_final got=%h exp=%h", obs_perf, want);
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) m_pg[i] = '0;
        for (int k = 0; k < ALU_LAT; k++) alu_stage[k] = '0;
        rst = 1'b1; kill = 1'b0; req_valid = '0; req_mask = '0;
        req_instr = '{default: M_ADD}; req_op1 = '0; req_op2 = '0; alu_result = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_round_robin();
        test_single();
        test_mask();
        test_kill();
        test_rst_mid();
        test_random();
        test_perf();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
